// File: rtl/sdram_arb_pkg.sv
// Shared types and the round-robin pick function for the SDRAM port arbiter.
package sdram_arb_pkg;

   localparam int unsigned MAX_PORTS = 8;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE
   } state_t;

   typedef struct packed {
      logic       valid;
      logic [2:0] idx;
   } pick_t;

   // First set request bit searching upward from ptr+1, wrapping modulo ports.
   function automatic pick_t rr_pick(input logic [MAX_PORTS-1:0] req,
                                     input logic [2:0]           ptr,
                                     input int unsigned          ports = MAX_PORTS);
      pick_t       r;
      int unsigned cand;
      logic [2:0]  c3;
      r = '0;
      for (int unsigned k = 1; k <= MAX_PORTS; k++) begin
         if (k <= ports) begin
            cand = (32'(ptr) + k) % ports;
            c3   = cand[2:0];
            if (!r.valid && req[c3]) begin
               r.valid = 1'b1;
               r.idx   = c3;
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational PORTS-wide round-robin pick; the port after i_ptr has top priority.
module rr_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int unsigned PORTS = 5,
   localparam int unsigned IW   = $clog2(PORTS)
) (
   input  logic [PORTS-1:0] i_req,
   input  logic [IW-1:0]    i_ptr,
   output logic             o_valid,
   output logic [IW-1:0]    o_idx
);

   logic [MAX_PORTS-1:0] w_req_ext;
   logic [2:0]           w_ptr_ext;
   pick_t                w_pick;

   assign w_req_ext = MAX_PORTS'(i_req);
   assign w_ptr_ext = 3'(i_ptr);
   assign w_pick    = rr_pick(w_req_ext, w_ptr_ext, PORTS);
   assign o_valid   = w_pick.valid;
   assign o_idx     = w_pick.idx[IW-1:0];

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller port among PORTS requesters. Round-robin grant,
// accesses launch on the clkref slot boundary, WAIT is bounded by TIMEOUT.
module sdram_port_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int unsigned PORTS     = 5,
   parameter int unsigned ADDRWIDTH = 22,
   parameter int unsigned SLOTLEN   = 6,
   parameter int unsigned TIMEOUT   = 1023
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [PORTS-1:0]           req,
   input  logic [PORTS-1:0]           we,
   input  logic [PORTS*ADDRWIDTH-1:0] addr,
   input  logic [PORTS*16-1:0]        din,
   input  logic [PORTS*2-1:0]         be,
   output logic [PORTS-1:0]           ack,
   output logic [15:0]                dout,
   output logic                       mem_req,
   output logic                       mem_we,
   output logic [ADDRWIDTH-1:0]       mem_addr,
   output logic [15:0]                mem_din,
   output logic [1:0]                 mem_be,
   input  logic                       mem_ack,
   input  logic [15:0]                mem_dout,
   output logic                       clkref,
   output logic [$clog2(PORTS)-1:0]   grant_idx,
   output logic                       timeout_err
);

   localparam int unsigned IW = $clog2(PORTS);
   localparam int unsigned PW = $clog2(SLOTLEN);
   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   state_t                 r_state, w_next;
   logic [PW-1:0]          r_phase;
   logic                   r_clkref;
   logic [IW-1:0]          r_ptr;
   logic [IW-1:0]          r_grant;
   logic [TW-1:0]          r_tmo;
   logic                   r_mem_req;
   logic                   r_mem_we;
   logic [ADDRWIDTH-1:0]   r_mem_addr;
   logic [15:0]            r_mem_din;
   logic [1:0]             r_mem_be;
   logic [PORTS-1:0]       r_ack;
   logic [15:0]            r_dout;
   logic                   r_terr;

   logic                   w_pick_valid;
   logic [IW-1:0]          w_pick_idx;
   logic                   w_phase_end;
   logic                   w_tmo_hit;
   logic                   w_latch, w_issue, w_ok, w_abort;

   rr_arbiter #(.PORTS(PORTS)) u_rr (
      .i_req   (req),
      .i_ptr   (r_ptr),
      .o_valid (w_pick_valid),
      .o_idx   (w_pick_idx)
   );

   assign w_phase_end = (r_phase == PW'(SLOTLEN - 1));
   assign w_tmo_hit   = (r_tmo == TW'(TIMEOUT - 1));

   // Free-running slot phase and registered clkref (high while phase==0).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_phase  <= '0;
         r_clkref <= 1'b0;
      end else begin
         r_phase  <= w_phase_end ? '0 : r_phase + 1'b1;
         r_clkref <= w_phase_end;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   // Next state and datapath strobes; mem_ack takes precedence over the timeout.
   always_comb begin
      w_next  = r_state;
      w_latch = 1'b0;
      w_issue = 1'b0;
      w_ok    = 1'b0;
      w_abort = 1'b0;
      case (r_state)
         IDLE:  if (w_pick_valid) begin w_latch = 1'b1; w_next = ISSUE; end
         ISSUE: if (w_phase_end)  begin w_issue = 1'b1; w_next = WAIT;  end
         WAIT: begin
            if (mem_ack)        begin w_ok    = 1'b1; w_next = DONE; end
            else if (w_tmo_hit) begin w_abort = 1'b1; w_next = DONE; end
         end
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Saturating count of cycles spent in WAIT.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                 r_tmo <= '0;
      else if (r_state != WAIT)  r_tmo <= '0;
      else if (r_tmo != '1)      r_tmo <= r_tmo + 1'b1;
   end

   // Grant capture, controller request, completion pulse, read data and error flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ptr      <= IW'(PORTS - 1);
         r_grant    <= '0;
         r_mem_req  <= 1'b0;
         r_mem_we   <= 1'b0;
         r_mem_addr <= '0;
         r_mem_din  <= '0;
         r_mem_be   <= '0;
         r_ack      <= '0;
         r_dout     <= '0;
         r_terr     <= 1'b0;
      end else begin
         r_ack <= '0;
         if (w_latch) begin
            r_ptr      <= w_pick_idx;
            r_grant    <= w_pick_idx;
            r_mem_we   <= we[w_pick_idx];
            r_mem_addr <= addr[w_pick_idx*ADDRWIDTH +: ADDRWIDTH];
            r_mem_din  <= din[w_pick_idx*16 +: 16];
            r_mem_be   <= be[w_pick_idx*2 +: 2];
         end
         if (w_issue) r_mem_req <= 1'b1;
         if (w_ok || w_abort) begin
            r_mem_req <= 1'b0;
            r_ack     <= PORTS'(1) << r_grant;
         end
         if (w_ok && !r_mem_we) r_dout <= mem_dout;
         if (w_abort) begin
            r_dout <= '0;
            r_terr <= 1'b1;
         end
      end
   end

   assign ack         = r_ack;
   assign dout        = r_dout;
   assign mem_req     = r_mem_req;
   assign mem_we      = r_mem_we;
   assign mem_addr    = r_mem_addr;
   assign mem_din     = r_mem_din;
   assign mem_be      = r_mem_be;
   assign clkref      = r_clkref;
   assign grant_idx   = r_grant;
   assign timeout_err = r_terr;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed scenario bench for sdram_port_arbiter (PORTS=5, SLOTLEN=6, TIMEOUT=20).
module tb_sdram_port_arbiter;

   localparam int P  = 5;
   localparam int AW = 22;
   localparam int SL = 6;
   localparam int TO = 20;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [P-1:0]    req = '0;
   logic [P-1:0]    we = '0;
   logic [P*AW-1:0] addr = '0;
   logic [P*16-1:0] din = '0;
   logic [P*2-1:0]  be = '0;
   logic [P-1:0]    ack;
   logic [15:0]     dout;
   logic            mem_req, mem_we;
   logic [AW-1:0]   mem_addr;
   logic [15:0]     mem_din;
   logic [1:0]      mem_be;
   logic            mem_ack = 1'b0;
   logic [15:0]     mem_dout = '0;
   logic            clkref;
   logic [2:0]      grant_idx;
   logic            timeout_err;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   logic [15:0] last_read = '0;

   sdram_port_arbiter #(.PORTS(P), .ADDRWIDTH(AW), .SLOTLEN(SL), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .din(din), .be(be),
      .ack(ack), .dout(dout), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_din(mem_din), .mem_be(mem_be), .mem_ack(mem_ack), .mem_dout(mem_dout),
      .clkref(clkref), .grant_idx(grant_idx), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_port(input int p, input logic w, input logic [AW-1:0] a,
                           input logic [15:0] d, input logic [1:0] b);
      we[p]            = w;
      addr[p*AW +: AW] = a;
      din[p*16 +: 16]  = d;
      be[p*2 +: 2]     = b;
   endtask

   task automatic wait_mem_req(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (mem_req) begin ok = 1'b1; break; end
      end
   endtask

   // Called one step after mem_req rose; mem_ack is seen on edge number dly.
   task automatic do_ack(input int dly, input logic [15:0] data);
      for (int i = 0; i < dly - 1; i++) step();
      mem_ack  = 1'b1;
      mem_dout = data;
      step();
      mem_ack  = 1'b0;
   endtask

   task automatic test_reset();
      int pulses, last;
      bit bad_space, noisy;
      reset = 1'b1;
      step(); step(); step();
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req got %b want 0", mem_req); end
      checks++; if (ack !== 5'b0) begin errors++; $display("FAIL rst_ack got %b want 00000", ack); end
      checks++; if (clkref !== 1'b0) begin errors++; $display("FAIL rst_clkref got %b want 0", clkref); end
      checks++; if ({grant_idx, dout, timeout_err} !== 20'h0) begin errors++;
         $display("FAIL rst_misc got grant=%0d dout=%h terr=%b want 0", grant_idx, dout, timeout_err); end
      reset = 1'b0;
      pulses = 0; last = 0; bad_space = 0; noisy = 0;
      for (int i = 0; i < 3 * SL; i++) begin
         step();
         if (mem_req !== 1'b0 || ack !== 5'b0 || grant_idx !== 3'd0) noisy = 1;
         if (clkref === 1'b1) begin
            if (pulses > 0 && cyc - last != SL) bad_space = 1;
            pulses++; last = cyc;
         end
      end
      checks++; if (pulses != 3) begin errors++; $display("FAIL clkref_count got %0d want 3", pulses); end
      checks++; if (bad_space) begin errors++; $display("FAIL clkref_period got irregular want %0d", SL); end
      checks++; if (noisy) begin errors++; $display("FAIL idle_quiet got activity want none"); end
      mem_ack = 1'b1; mem_dout = 16'hFFFF;
      step();
      mem_ack = 1'b0;
      noisy = (ack !== 5'b0);
      step();
      if (ack !== 5'b0) noisy = 1;
      checks++; if (noisy || dout !== 16'h0000) begin errors++;
         $display("FAIL stray_mem_ack got ack=%b dout=%h want 00000 0000", ack, dout); end
   endtask

   task automatic test_single_read();
      bit ok;
      set_port(2, 1'b0, 22'h1234, 16'h0, 2'b11);
      req[2] = 1'b1;
      wait_mem_req(ok);
      checks++; if (!ok) begin errors++; $display("FAIL rd_mem_req got timeout want rise"); end
      checks++; if (clkref !== 1'b1) begin errors++; $display("FAIL rd_clkref_align got %b want 1", clkref); end
      checks++; if (mem_addr !== 22'h1234 || mem_we !== 1'b0) begin errors++;
         $display("FAIL rd_cmd got addr=%h we=%b want 001234 0", mem_addr, mem_we); end
      checks++; if (grant_idx !== 3'd2) begin errors++; $display("FAIL rd_grant got %0d want 2", grant_idx); end
      addr[2*AW +: AW] = 22'h3FFFFF;
      do_ack(3, 16'hA55A);
      checks++; if (ack !== 5'b00100) begin errors++; $display("FAIL rd_ack got %b want 00100", ack); end
      checks++; if (dout !== 16'hA55A) begin errors++; $display("FAIL rd_dout got %h want a55a", dout); end
      checks++; if (mem_req !== 1'b0 || mem_addr !== 22'h1234) begin errors++;
         $display("FAIL rd_release got req=%b addr=%h want 0 001234", mem_req, mem_addr); end
      req[2] = 1'b0;
      last_read = 16'hA55A;
      step();
      checks++; if (ack !== 5'b0) begin errors++; $display("FAIL rd_ack_width got %b want 00000", ack); end
   endtask

   task automatic test_round_robin();
      bit ok;
      int prev, exp;
      reset = 1'b1; step(); step(); reset = 1'b0;
      for (int p = 0; p < P; p++) set_port(p, 1'b0, AW'(32'h100 + p), 16'h0, 2'b11);
      req = '1;
      prev = 0;
      for (int n = 0; n < 7; n++) begin
         exp = n % P;
         wait_mem_req(ok);
         checks++; if (!ok) begin errors++; $display("FAIL rr_mem_req[%0d] got timeout want rise", n); end
         checks++; if (grant_idx !== 3'(exp) || mem_addr !== AW'(32'h100 + exp)) begin errors++;
            $display("FAIL rr_grant[%0d] got %0d addr=%h want %0d", n, grant_idx, mem_addr, exp); end
         if (n > 0) begin
            checks++; if ((cyc - prev) % SL != 0) begin errors++;
               $display("FAIL rr_spacing[%0d] got %0d want multiple of %0d", n, cyc - prev, SL); end
         end
         prev = cyc;
         do_ack(1, 16'hC000 + 16'(n));
         checks++; if (ack !== 5'(1 << exp)) begin errors++;
            $display("FAIL rr_ack[%0d] got %b want %b", n, ack, 5'(1 << exp)); end
      end
      req = '0;
      last_read = 16'hC006;
      step();
   endtask

   task automatic test_write();
      bit ok;
      set_port(1, 1'b1, 22'h2AAAA, 16'hBEEF, 2'b10);
      req[1] = 1'b1;
      wait_mem_req(ok);
      checks++; if (!ok) begin errors++; $display("FAIL wr_mem_req got timeout want rise"); end
      checks++; if (mem_we !== 1'b1 || mem_din !== 16'hBEEF || mem_be !== 2'b10 || mem_addr !== 22'h2AAAA) begin
         errors++; $display("FAIL wr_cmd got we=%b din=%h be=%b addr=%h want 1 beef 10 02aaaa",
                            mem_we, mem_din, mem_be, mem_addr); end
      do_ack(2, 16'h1111);
      checks++; if (ack !== 5'b00010) begin errors++; $display("FAIL wr_ack got %b want 00010", ack); end
      checks++; if (dout !== last_read) begin errors++; $display("FAIL wr_dout_hold got %h want %h", dout, last_read); end
      req[1] = 1'b0;
      we[1]  = 1'b0;
      step();
   endtask

   task automatic test_ack_at_limit();
      bit ok;
      set_port(0, 1'b0, 22'h3, 16'h0, 2'b11);
      req[0] = 1'b1;
      wait_mem_req(ok);
      checks++; if (!ok) begin errors++; $display("FAIL lim_mem_req got timeout want rise"); end
      do_ack(TO, 16'h5A5A);
      checks++; if (ack !== 5'b00001 || dout !== 16'h5A5A) begin errors++;
         $display("FAIL lim_ack got ack=%b dout=%h want 00001 5a5a", ack, dout); end
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL lim_no_err got %b want 0", timeout_err); end
      req[0] = 1'b0;
      last_read = 16'h5A5A;
      step();
   endtask

   task automatic test_timeout();
      bit ok, early;
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_pre got %b want 0", timeout_err); end
      set_port(3, 1'b0, 22'h777, 16'h0, 2'b11);
      req[3] = 1'b1;
      wait_mem_req(ok);
      checks++; if (!ok) begin errors++; $display("FAIL to_mem_req got timeout want rise"); end
      early = 0;
      for (int i = 0; i < TO - 1; i++) begin
         step();
         if (mem_req !== 1'b1 || ack !== 5'b0) early = 1;
      end
      checks++; if (early) begin errors++; $display("FAIL to_early got abort before %0d want none", TO); end
      step();
      checks++; if (mem_req !== 1'b0 || ack !== 5'b01000) begin errors++;
         $display("FAIL to_abort got req=%b ack=%b want 0 01000", mem_req, ack); end
      checks++; if (dout !== 16'h0000 || timeout_err !== 1'b1) begin errors++;
         $display("FAIL to_flags got dout=%h terr=%b want 0000 1", dout, timeout_err); end
      req[3] = 1'b0;
      for (int i = 0; i < 8; i++) step();
      checks++; if (timeout_err !== 1'b1 || ack !== 5'b0) begin errors++;
         $display("FAIL to_sticky got terr=%b ack=%b want 1 00000", timeout_err, ack); end
   endtask

   task automatic test_reset_mid_access();
      bit ok, acked;
      set_port(1, 1'b0, 22'h111, 16'h0, 2'b11);
      set_port(3, 1'b0, 22'h333, 16'h0, 2'b11);
      set_port(4, 1'b0, 22'h444, 16'h0, 2'b11);
      req[3] = 1'b1;
      wait_mem_req(ok);
      checks++; if (!ok || grant_idx !== 3'd3) begin errors++;
         $display("FAIL mid_grant got ok=%b grant=%0d want 1 3", ok, grant_idx); end
      step();
      req[1] = 1'b1; req[4] = 1'b1;
      #1 reset = 1'b1;
      #1;
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL mid_drop got %b want 0", mem_req); end
      acked = 0;
      for (int i = 0; i < 2; i++) begin
         step();
         if (ack !== 5'b0) acked = 1;
      end
      checks++; if (acked || timeout_err !== 1'b0) begin errors++;
         $display("FAIL mid_quiet got ack_seen=%b terr=%b want 0 0", acked, timeout_err); end
      reset = 1'b0;
      wait_mem_req(ok);
      checks++; if (!ok || grant_idx !== 3'd1 || mem_addr !== 22'h111) begin errors++;
         $display("FAIL mid_regrant got ok=%b grant=%0d addr=%h want 1 1 000111", ok, grant_idx, mem_addr); end
      do_ack(1, 16'h7777);
      checks++; if (ack !== 5'b00010 || dout !== 16'h7777) begin errors++;
         $display("FAIL mid_ack got ack=%b dout=%h want 00010 7777", ack, dout); end
      req = '0;
      step();
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_round_robin();
      test_write();
      test_ack_at_limit();
      test_timeout();
      test_reset_mid_access();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
